// File: rtl/alu_uart_pkg.sv
// rtl/alu_uart_pkg.sv - shared types and constants for the ALU serial command front-end
package alu_uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [3:0] SYNC_MARKER = 4'hA;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_INC  = 4'd10,
    OP_DEC  = 4'd11,
    OP_NAND = 4'd12,
    OP_NOR  = 4'd13,
    OP_LT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: two-flop synchroniser, byte FSM, bit counter
module uart_rx_byte
  import alu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       rx_active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q;
  logic            rx_s_q;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            stop_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      case (state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            // A start bit that is high again at its centre was line noise.
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s_q, shreg_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  // Strobes are decoded in the stop-sample cycle so the frame stage can register them once.
  assign stop_sample = (state_q == RX_STOP) && (cnt_q == BIT_LAST);
  assign byte_valid  = stop_sample && rx_s_q;
  assign stop_err    = stop_sample && !rx_s_q;
  assign byte_data   = shreg_q;
  assign rx_active   = (state_q != RX_IDLE);

endmodule

// File: rtl/alu_cmd_uart_rx.sv
// rtl/alu_cmd_uart_rx.sv - two-byte UART command frame assembler feeding the 4-bit ALU
module alu_cmd_uart_rx
  import alu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] operands,
  output logic [3:0] opcode,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          stop_err;
  logic          rx_active;

  logic          idx_q, idx_d;
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    operands_q, operands_d;
  logic [3:0]    opcode_q, opcode_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [TW-1:0] to_q, to_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .stop_err  (stop_err),
    .rx_active (rx_active)
  );

  always_comb begin
    idx_d       = idx_q;
    pend_d      = pend_q;
    operands_d  = operands_q;
    opcode_d    = opcode_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    to_d        = to_q;
    if (stop_err) begin
      frame_err_d = 1'b1;
      idx_d       = 1'b0;
      to_d        = '0;
    end else if (byte_valid) begin
      to_d = '0;
      if (!idx_q) begin
        pend_d = byte_data;
        idx_d  = 1'b1;
      end else if (byte_data[7:4] == SYNC_MARKER) begin
        operands_d  = pend_q;
        opcode_d    = byte_data[3:0];
        cmd_valid_d = 1'b1;
        idx_d       = 1'b0;
      end else begin
        // Bad marker drops the whole frame; the byte is not reused as a new byte 0.
        frame_err_d = 1'b1;
        idx_d       = 1'b0;
      end
    end else if (idx_q && !rx_active) begin
      if (to_q == TO_LAST) begin
        idx_d = 1'b0;
        to_d  = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= 1'b0;
      pend_q      <= '0;
      operands_q  <= '0;
      opcode_q    <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      to_q        <= '0;
    end else begin
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      operands_q  <= operands_d;
      opcode_q    <= opcode_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      to_q        <= to_d;
    end
  end

  assign operands  = operands_q;
  assign opcode    = opcode_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = rx_active || idx_q;

endmodule

// File: tb/tb_alu_cmd_uart_rx.sv
// tb/tb_alu_cmd_uart_rx.sv - scoreboard bench for the ALU UART command front-end
module tb_alu_cmd_uart_rx;
  import alu_uart_pkg::*;

  localparam int N = 8;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] operands;
  logic [3:0] opcode;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;

  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    int         kind;
    logic [7:0] ops;
    logic [3:0] opc;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  alu_cmd_uart_rx #(
    .CLKS_PER_BIT(N),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .operands (operands),
    .opcode   (opcode),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind 1 = cmd_valid, kind 2 = frame_err
  always @(negedge clk) begin
    if (!rst && (cmd_valid || frame_err)) begin
      check("pulse_exclusive", {31'd0, cmd_valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_pulse: cmd_valid=%0b frame_err=%0b at cycle %0d, no pulse expected",
                 cmd_valid, frame_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", cmd_valid ? 32'd1 : 32'd2, mon_e.kind);
        if (mon_e.kind == 1) begin
          check("cmd_operands", {24'd0, operands}, {24'd0, mon_e.ops});
          check("cmd_opcode", {28'd0, opcode}, {28'd0, mon_e.opc});
        end
        if (mon_e.t >= 0) check("pulse_cycle", cyc, mon_e.t);
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int kind,
                           input logic [7:0] eops, input logic [3:0] eopc, input bit chk_t);
    exp_t e;
    if (kind != 0) begin
      e.kind = kind;
      e.ops  = eops;
      e.opc  = eopc;
      // 2 sync flops + 1 edge to leave IDLE, then H + 9N to the stop sample.
      e.t    = chk_t ? cyc + 3 + H + 9 * N : -1;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (N) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (N) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_operands"}, {24'd0, operands}, 32'd0);
    check({tag, "_opcode"}, {28'd0, opcode}, 32'd0);
    check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] partial;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(5);

    // Good frame with pulse timing check.
    send_byte(8'h53, 1'b1, 0, 8'h00, 4'h0, 1'b0);
    send_byte(8'hA0, 1'b1, 1, 8'h53, OP_ADD, 1'b1);
    idle(4);
    check("alu_add_result", {28'd0, operands[3:0]} + {28'd0, operands[7:4]}, 32'd8);

    // Bad stop bit on byte 1: error, outputs keep last command.
    send_byte(8'h11, 1'b1, 0, 8'h00, 4'h0, 1'b0);
    send_byte(8'hA5, 1'b0, 2, 8'h00, 4'h0, 1'b0);
    idle(20);
    check("badstop_operands_hold", {24'd0, operands}, 32'h53);
    check("badstop_opcode_hold", {28'd0, opcode}, 32'h0);
    check("badstop_busy", {31'd0, busy}, 32'd0);

    // Bad marker, then recovery.
    send_byte(8'h12, 1'b1, 0, 8'h00, 4'h0, 1'b0);
    send_byte(8'h53, 1'b1, 2, 8'h00, 4'h0, 1'b0);
    idle(4);
    send_byte(8'h21, 1'b1, 0, 8'h00, 4'h0, 1'b0);
    send_byte(8'hA3, 1'b1, 1, 8'h21, 4'h3, 1'b0);
    idle(4);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    idle(10);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_operands_hold", {24'd0, operands}, 32'h21);

    // Timeout drops the pending byte 0.
    send_byte(8'h77, 1'b1, 0, 8'h00, 4'h0, 1'b0);
    check("timeout_pending_busy", {31'd0, busy}, 32'd1);
    idle(200);
    check("timeout_busy_cleared", {31'd0, busy}, 32'd0);
    send_byte(8'h45, 1'b1, 0, 8'h00, 4'h0, 1'b0);
    send_byte(8'hAD, 1'b1, 1, 8'h45, 4'hD, 1'b0);
    idle(4);

    // Reset during data bit 4 of byte 1.
    send_byte(8'h33, 1'b1, 0, 8'h00, 4'h0, 1'b0);
    partial = 8'hA1;
    rx = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (N) @(posedge clk);
      #1;
    end
    rx = partial[4];
    repeat (H) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("midreset");
    rx  = 1'b1;
    rst = 1'b0;
    idle(5);
    send_byte(8'h9C, 1'b1, 0, 8'h00, 4'h0, 1'b0);
    send_byte(8'hAF, 1'b1, 1, 8'h9C, 4'hF, 1'b0);
    idle(6);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
